// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Decode-stage hazard unit for the 5-stage MIPS core. A per-register latency
// scoreboard records how many cycles remain until each in-flight result can be
// forwarded into E. A separate counter tracks how long the multiply/divide
// unit stays busy. A small FSM drains the pipeline before a syscall and then
// holds fetch/decode for a fixed number of cycles after it.
//
// Handshake: an instruction in D is offered with issue_valid_d. It issues on
// the rising edge at which issue_valid_d = 1 and stall_d = 0. While stall_d = 1,
// the D inputs must be held stable. Scoreboard and MDU updates happen only on
// the issuing edge.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   issue_valid_d       a valid instruction occupies D
//   rs_d / rs_used_d    source A address and its use flag
//   rt_d / rt_used_d    source B address and its use flag
//   dest_d/reg_write_d  destination register and its write flag
//   result_lat_d        cycles until the result is forwardable to E
//   branch_d            operands are consumed in D (branch / jr)
//   mdu_op_d            instruction occupies the multiply/divide unit
//   syscall_d           syscall in D
//   stall_f, stall_d    hold PC / hold the F/D register
//   flush_e             insert a bubble into D/E
//   pending             bit r set while cnt[r] != 0
//   mdu_busy            MDU counter nonzero
//   sys_state_dbg       syscall FSM state (0 IDLE, 1 DRAIN, 2 HOLD)
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REG_ADDR_W   = 5,
  parameter int LAT_W        = 3,
  parameter int MDU_LAT      = 4,
  parameter int SYSCALL_HOLD = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid_d,
  input  logic [REG_ADDR_W-1:0]      rs_d,
  input  logic [REG_ADDR_W-1:0]      rt_d,
  input  logic                       rs_used_d,
  input  logic                       rt_used_d,
  input  logic [REG_ADDR_W-1:0]      dest_d,
  input  logic                       reg_write_d,
  input  logic [LAT_W-1:0]           result_lat_d,
  input  logic                       branch_d,
  input  logic                       mdu_op_d,
  input  logic                       syscall_d,
  output logic                       stall_f,
  output logic                       stall_d,
  output logic                       flush_e,
  output logic [2**REG_ADDR_W-1:0]   pending,
  output logic                       mdu_busy,
  output logic [1:0]                 sys_state_dbg
);

  localparam int NREG   = 2**REG_ADDR_W;
  localparam int HOLD_W = (SYSCALL_HOLD < 2) ? 1 : $clog2(SYSCALL_HOLD + 1);

  typedef enum logic [1:0] {
    SYS_IDLE  = 2'd0,
    SYS_DRAIN = 2'd1,
    SYS_HOLD  = 2'd2
  } sys_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [LAT_W-1:0]  cnt_q [NREG];
  logic [LAT_W-1:0]  cnt_d [NREG];
  logic [LAT_W-1:0]  mdu_cnt_q, mdu_cnt_d;
  sys_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // ---------------------------------------------------------------------------
  // Status views of the counters
  // ---------------------------------------------------------------------------
  logic any_pending;
  logic mdu_busy_w;

  always_comb begin
    pending = '0;
    for (int r = 1; r < NREG; r++) begin
      pending[r] = (cnt_q[r] != '0);
    end
  end

  assign any_pending = |pending;
  assign mdu_busy_w  = (mdu_cnt_q != '0);
  assign mdu_busy    = mdu_busy_w;

  // ---------------------------------------------------------------------------
  // Hazard checks
  // ---------------------------------------------------------------------------
  // A normal consumer picks its operand up from M or W on entry to E, so one
  // remaining cycle is still fine. A branch reads in D and needs the value
  // already sitting in M, so the entry must be zero.
  function automatic logic src_blocked(input logic             used,
                                       input logic             nonzero,
                                       input logic [LAT_W-1:0] lat,
                                       input logic             br);
    if (!used || !nonzero) begin
      return 1'b0;
    end
    return br ? (lat != '0) : (lat > LAT_W'(1));
  endfunction

  logic [LAT_W-1:0] rs_lat, rt_lat, dest_lat;
  logic             raw_stall, waw_stall, mdu_stall, core_hz;
  logic             sys_stall, hz, hold_active, issue;

  assign rs_lat   = cnt_q[rs_d];
  assign rt_lat   = cnt_q[rt_d];
  assign dest_lat = cnt_q[dest_d];

  // When rs_d == rt_d both terms evaluate identically, so the OR is one check.
  assign raw_stall = issue_valid_d &&
                     (src_blocked(rs_used_d, rs_d != '0, rs_lat, branch_d) ||
                      src_blocked(rt_used_d, rt_d != '0, rt_lat, branch_d));

  // A younger write must not land before an older in-flight write to the
  // same register.
  assign waw_stall = issue_valid_d && reg_write_d && (dest_d != '0) &&
                     (dest_lat > result_lat_d);

  assign mdu_stall = issue_valid_d && mdu_op_d && mdu_busy_w;

  assign core_hz     = raw_stall || waw_stall || mdu_stall;
  assign hold_active = (state_q == SYS_HOLD);
  assign hz          = core_hz || sys_stall;

  // Outputs are forced low while reset is asserted, independent of D inputs.
  assign stall_f = rst_n && (hz || hold_active);
  assign stall_d = rst_n && (hz || hold_active);
  assign flush_e = rst_n && hz && !hold_active;

  assign issue = issue_valid_d && !(hz || hold_active);

  // ---------------------------------------------------------------------------
  // Syscall drain/hold FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    sys_stall = 1'b0;
    unique case (state_q)
      SYS_IDLE: begin
        if (issue_valid_d && syscall_d) begin
          if (any_pending || mdu_busy_w) begin
            sys_stall = 1'b1;
            state_d   = SYS_DRAIN;
          end else if (!core_hz) begin
            // Syscall issues this cycle.
            if (SYSCALL_HOLD > 0) begin
              state_d = SYS_HOLD;
              hold_d  = HOLD_W'(SYSCALL_HOLD);
            end
          end
        end
      end
      SYS_DRAIN: begin
        if (any_pending || mdu_busy_w) begin
          sys_stall = 1'b1;
        end else if (!core_hz) begin
          // Pipeline drained; the held syscall issues this cycle.
          if (SYSCALL_HOLD > 0) begin
            state_d = SYS_HOLD;
            hold_d  = HOLD_W'(SYSCALL_HOLD);
          end else begin
            state_d = SYS_IDLE;
          end
        end
      end
      SYS_HOLD: begin
        // The cycle with the counter at 1 is the last frozen cycle.
        if (hold_q <= HOLD_W'(1)) begin
          state_d = SYS_IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = SYS_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  assign sys_state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // Counter next state
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (issue && reg_write_d && (dest_d == REG_ADDR_W'(r))) begin
        // Issue load wins over the decrement of the same entry.
        cnt_d[r] = result_lat_d;
      end
    end
  end

  always_comb begin
    mdu_cnt_d = mdu_busy_w ? mdu_cnt_q - LAT_W'(1) : '0;
    if (issue && mdu_op_d) begin
      mdu_cnt_d = LAT_W'(MDU_LAT);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      mdu_cnt_q <= '0;
      state_q   <= SYS_IDLE;
      hold_q    <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      mdu_cnt_q <= mdu_cnt_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard. A model based on absolute cycle
// numbers ("register r is ready at cycle N") predicts every output each
// cycle; hand-computed stall counts and literal values pin the model.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int RW       = 5;
  localparam int LW       = 3;
  localparam int MDU_LAT  = 4;
  localparam int SYS_HOLD = 2;
  localparam int NREG     = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            issue_valid_d = 1'b0;
  logic [RW-1:0]   rs_d = '0, rt_d = '0, dest_d = '0;
  logic            rs_used_d = 1'b0, rt_used_d = 1'b0, reg_write_d = 1'b0;
  logic [LW-1:0]   result_lat_d = '0;
  logic            branch_d = 1'b0, mdu_op_d = 1'b0, syscall_d = 1'b0;
  logic            stall_f, stall_d, flush_e, mdu_busy;
  logic [NREG-1:0] pending;
  logic [1:0]      sys_state_dbg;

  hazard_scoreboard #(
    .REG_ADDR_W  (RW),
    .LAT_W       (LW),
    .MDU_LAT     (MDU_LAT),
    .SYSCALL_HOLD(SYS_HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid_d(issue_valid_d),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .rs_used_d    (rs_used_d),
    .rt_used_d    (rt_used_d),
    .dest_d       (dest_d),
    .reg_write_d  (reg_write_d),
    .result_lat_d (result_lat_d),
    .branch_d     (branch_d),
    .mdu_op_d     (mdu_op_d),
    .syscall_d    (syscall_d),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_e      (flush_e),
    .pending      (pending),
    .mdu_busy     (mdu_busy),
    .sys_state_dbg(sys_state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: absolute ready cycles
  // ---------------------------------------------------------------------------
  longint now_c = 0;
  longint ready_at [NREG];
  longint mdu_ready = 0;
  longint hold_end  = 0;
  bit     draining  = 0;

  bit            m_issue = 0, m_sys_issue = 0, m_drain_next = 0;
  bit            m_wr = 0, m_mdu = 0;
  logic [RW-1:0] m_dest = '0;
  int            m_lat = 0;

  initial begin
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
  end

  function automatic int rem(input int r);
    if (r == 0 || ready_at[r] <= now_c) return 0;
    return int'(ready_at[r] - now_c);
  endfunction

  function automatic int mdu_rem();
    if (mdu_ready <= now_c) return 0;
    return int'(mdu_ready - now_c);
  endfunction

  always @(negedge rst_n) begin
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    mdu_ready    = 0;
    hold_end     = 0;
    draining     = 0;
    m_issue      = 0;
    m_sys_issue  = 0;
    m_drain_next = 0;
  end

  // Compare process: predicts outputs from the model and current D inputs.
  always @(negedge clk) begin
    bit busy, raw, waw, mst, in_hold, sys, hz, e_stall, e_flush;
    logic [NREG-1:0] e_pend;
    int e_state;
    busy = 0; raw = 0; waw = 0; mst = 0;
    e_pend = '0;
    for (int r = 1; r < NREG; r++) begin
      if (rem(r) > 0) begin
        e_pend[r] = 1'b1;
        busy = 1;
      end
    end
    if (mdu_rem() > 0) busy = 1;
    in_hold = (now_c < hold_end);
    if (issue_valid_d) begin
      if (rs_used_d && rs_d != 0) raw |= branch_d ? (rem(int'(rs_d)) != 0) : (rem(int'(rs_d)) > 1);
      if (rt_used_d && rt_d != 0) raw |= branch_d ? (rem(int'(rt_d)) != 0) : (rem(int'(rt_d)) > 1);
      waw = reg_write_d && dest_d != 0 && (rem(int'(dest_d)) > int'(result_lat_d));
      mst = mdu_op_d && (mdu_rem() > 0);
    end
    sys     = !in_hold && (draining ? busy : (issue_valid_d && syscall_d && busy));
    hz      = raw || waw || mst || sys;
    e_stall = hz || in_hold;
    e_flush = hz && !in_hold;
    e_state = in_hold ? 2 : (draining ? 1 : 0);
    if (rst_n) begin
      check("stall_f", stall_f, e_stall);
      check("stall_d", stall_d, e_stall);
      check("flush_e", flush_e, e_flush);
      check("pending", pending, e_pend);
      check("mdu_busy", mdu_busy, mdu_rem() > 0);
      check("sys_state", sys_state_dbg, e_state);
    end
    m_issue      = rst_n && issue_valid_d && !e_stall;
    m_wr         = reg_write_d;
    m_dest       = dest_d;
    m_lat        = int'(result_lat_d);
    m_mdu        = mdu_op_d;
    m_sys_issue  = rst_n && !in_hold && !busy && !(raw || waw || mst) &&
                   (draining || (issue_valid_d && syscall_d));
    m_drain_next = rst_n && !in_hold && busy && (draining || (issue_valid_d && syscall_d));
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_issue && m_wr && m_dest != 0) ready_at[m_dest] = now_c + 1 + m_lat;
      if (m_issue && m_mdu) mdu_ready = now_c + 1 + MDU_LAT;
      if (m_sys_issue && SYS_HOLD > 0) hold_end = now_c + 1 + SYS_HOLD;
      draining = m_drain_next;
    end
    now_c = now_c + 1;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [RW-1:0] rs, input logic rsu,
                       input logic [RW-1:0] rt, input logic rtu,
                       input logic [RW-1:0] dest, input logic wr, input logic [LW-1:0] lat,
                       input logic br, input logic mdu, input logic sys);
    issue_valid_d = 1'b1;
    rs_d = rs; rs_used_d = rsu;
    rt_d = rt; rt_used_d = rtu;
    dest_d = dest; reg_write_d = wr; result_lat_d = lat;
    branch_d = br; mdu_op_d = mdu; syscall_d = sys;
  endtask

  task automatic idle(input int n);
    issue_valid_d = 1'b0;
    reg_write_d = 1'b0; mdu_op_d = 1'b0; syscall_d = 1'b0;
    rs_used_d = 1'b0; rt_used_d = 1'b0; branch_d = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one instruction and holds it until it issues; checks the stall count.
  task automatic run_instr(input string name,
                           input logic [RW-1:0] rs, input logic rsu,
                           input logic [RW-1:0] rt, input logic rtu,
                           input logic [RW-1:0] dest, input logic wr, input logic [LW-1:0] lat,
                           input logic br, input logic mdu, input logic sys,
                           input int exp_stalls);
    int  stalls;
    bit  done;
    stalls = 0;
    done   = 0;
    drive(rs, rsu, rt, rtu, dest, wr, lat, br, mdu, sys);
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (stall_d) stalls++;
      else done = 1;
      @(posedge clk);
      #1;
    end
    check({name, "_issued"}, done, 1'b1);
    check({name, "_stalls"}, stalls, exp_stalls);
    issue_valid_d = 1'b0;
    reg_write_d = 1'b0; mdu_op_d = 1'b0; syscall_d = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall_f", stall_f, 1'b0);
    check("rst_flush_e", flush_e, 1'b0);
    check("rst_pending", pending, 32'h0);
    check("rst_mdu_busy", mdu_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load r8 (lat 2) then add r8,r8: one stall, pending[8] clears after.
    run_instr("load_r8", 0, 0, 0, 0, 8, 1, 2, 0, 0, 0, 0);
    check("load_r8_pending", pending[8], 1'b1);
    run_instr("add_r8", 8, 1, 8, 1, 11, 1, 1, 0, 0, 0, 1);
    check("add_r8_pending", pending[8], 1'b0);
    idle(2);

    // ALU r9 then beq r9: one stall. ALU r9 then add r9: no stall.
    run_instr("alu_r9", 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0);
    run_instr("beq_r9", 9, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1);
    run_instr("alu_r9b", 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0);
    run_instr("add_r9", 9, 1, 3, 1, 12, 1, 1, 0, 0, 0, 0);
    idle(2);

    // Back-to-back MDU ops: the second waits while mdu_cnt counts 4,3,2,1.
    run_instr("mdu_a", 4, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
    check("mdu_a_busy", mdu_busy, 1'b1);
    run_instr("mdu_b", 6, 1, 7, 1, 0, 0, 0, 0, 1, 0, 4);
    idle(6);

    // WAW: MDU write r10 (lat 4) then ALU write r10 (lat 1).
    run_instr("mdu_r10", 0, 0, 0, 0, 10, 1, 4, 0, 1, 0, 0);
    run_instr("waw_r10", 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 3);
    idle(3);

    // Load r2 then syscall: drain 2 cycles, then HOLD 2 cycles.
    run_instr("load_r2", 0, 0, 0, 0, 2, 1, 2, 0, 0, 0, 0);
    run_instr("syscall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    #1;
    check("hold_stall_f", stall_f, 1'b1);
    check("hold_flush_e", flush_e, 1'b0);
    check("hold_state", sys_state_dbg, 2'd2);
    run_instr("after_hold", 1, 1, 0, 0, 13, 1, 1, 0, 0, 0, 2);
    idle(2);

    // Zero latency sets nothing; dest 0 is ignored.
    run_instr("lat0_r5", 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    check("lat0_pending", pending[5], 1'b0);
    run_instr("beq_r5", 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    run_instr("wr_r0", 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    check("wr_r0_pending", pending, 32'h0);
    run_instr("beq_r0", 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    idle(2);

    // Reset during DRAIN with pending[4] set.
    run_instr("load_r4", 0, 0, 0, 0, 4, 1, 2, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #2;
    check("drain_state", sys_state_dbg, 2'd1);
    check("drain_pend4", pending[4], 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall_f", stall_f, 1'b0);
    check("rst_mid_stall_d", stall_d, 1'b0);
    check("rst_mid_flush_e", flush_e, 1'b0);
    check("rst_mid_pending", pending, 32'h0);
    check("rst_mid_state", sys_state_dbg, 2'd0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_pending", pending, 32'h0);
    check("post_rst_state", sys_state_dbg, 2'd0);
    run_instr("use_r4", 4, 1, 0, 0, 14, 1, 1, 0, 0, 0, 0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
